password_lock_ctrl: RTL
=======================

# password_lock_ctrl

Sequencing controller for the switch-entry password lock. It turns rising edges on `SW[9:0]` into digit events and collects a 4-digit code. It compares that code against a parameterised secret, counts failed attempts and enforces a timed lockout. It drives the board LEDs and sits between the raw switch inputs and the unlock/indicator outputs.

## Interface
- `CODE0` default 2: first secret digit (0..9).
- `CODE1` default 0: second secret digit.
- `CODE2` default 1: third secret digit.
- `CODE3` default 6: fourth secret digit.
- `MAX_TRIES` default 3: consecutive failures that trigger lockout (1..7).
- `OPEN_CYCLES` default 50_000_000: cycles held in OPEN.
- `LOCK_CYCLES` default 500_000_000: cycles held in LOCKED.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `SW` in 10: slide switches; a 0→1 edge on bit k is digit k.
- `pswd_out_LED` out 4: progress/status indicator.
- `unlocked` out 1: high only in OPEN.
- `locked` out 1: high only in LOCKED.
- `fail_cnt` out 3: consecutive failed attempts.

## Operation
- Edge detect:
  - `sw_q` is a registered copy of `SW`; `edge = SW & ~sw_q`.
  - While `rst`=0, `sw_q` loads `SW`, so switches already high at reset produce no edge.
- Digit event: any cycle with `edge != 0`.
  - Exactly one bit set: digit = its index.
  - More than one bit set: the event counts as a wrong digit.
- A mismatch flag is set if any entered digit differs from `CODE[idx]`. The comparison is incremental; no digit history is stored.
- States:
  - IDLE: `idx`=0, mismatch cleared. A digit event records it and goes to ENTRY with `idx`=1.
  - ENTRY: each digit event increments `idx`. The event that makes `idx`=4 goes to CHECK.
  - CHECK: one cycle. Mismatch=0 → OPEN. Mismatch=1 → FAIL.
  - OPEN: clears `fail_cnt` on entry and counts OPEN_CYCLES, then → IDLE.
  - FAIL: one cycle, `fail_cnt`+1.
    - If the new value ≥ MAX_TRIES → LOCKED.
    - Otherwise → IDLE.
  - LOCKED: counts LOCK_CYCLES, then clears `fail_cnt` and → IDLE.
- Digit events in CHECK, OPEN, FAIL and LOCKED are ignored; they are not buffered. `sw_q` keeps tracking.
- `fail_cnt` saturates at 7.
- `pswd_out_LED`:
  - IDLE/ENTRY: thermometer of `idx` (0000, 0001, 0011, 0111).
  - CHECK: 1111.
  - OPEN: 1111.
  - FAIL: 0000.
  - LOCKED: 1010.
- The dwell counter is 29 bits wide and shared by OPEN and LOCKED. It is cleared on every state entry.

## Timing
- Reset values: state IDLE, `pswd_out_LED`=0000, `unlocked`=0, `locked`=0, `fail_cnt`=0, `idx`=0, dwell counter 0.
- Reset asserted mid-operation, in any state, returns to these values at the next edge.
- Reset wins over all other events.
- `SW` rises before clock edge n: edge detected in cycle n; `pswd_out_LED`/`idx` update after edge n+1.
- 4th digit at edge n: CHECK during n+1, OPEN/FAIL visible after edge n+2.
- `unlocked` is high for exactly OPEN_CYCLES cycles; `locked` is high for exactly LOCK_CYCLES cycles.
- A switch falling and rising again in consecutive cycles yields two edges and two digits. Debouncing is external.
- All outputs are registered.

## Configuration
- `PSWD_LOCKOUT_EN` defined: FAIL → LOCKED behaviour exactly as above.
- `PSWD_LOCKOUT_EN` undefined:
  - LOCKED is never entered; `locked` is tied 0.
  - FAIL always → IDLE.
  - `fail_cnt` still counts, saturates at 7 and is cleared by OPEN.
  - MAX_TRIES and LOCK_CYCLES are unused.

## Test plan
Bench parameters: OPEN_CYCLES=20, LOCK_CYCLES=50, `PSWD_LOCKOUT_EN` defined unless noted.
- Correct code: rst low 5 cycles → high, then pulse SW[2], SW[0], SW[1], SW[6] (each high 10 cycles, low 10) → LEDs 0001, 0011, 0111, then 1111; `unlocked`=1 for 20 cycles; `fail_cnt`=0; back to IDLE with LEDs 0000.
- Wrong code: SW[2], SW[0], SW[1], SW[5] → one FAIL cycle (LEDs 0000), `fail_cnt`=1, `unlocked` never high.
- Lockout: three wrong entries → `locked`=1, LEDs 1010 for 50 cycles. Pulsing SW[2] during LOCKED has no effect. Afterwards `fail_cnt`=0 and IDLE.
- Simultaneous edges / reset hold:
  - SW[2] and SW[3] rise in the same cycle as digit 1, then correct 0, 1, 6 → FAIL.
  - SW[9] held high through reset release → no digit registered.
- Reset mid-entry: after 2 digits, drop rst for 1 cycle → LEDs 0000, `idx`=0. A full correct code then unlocks.
- Macro off: five wrong entries → `locked` stays 0, `fail_cnt`=5. A correct code then opens and clears `fail_cnt` to 0.

Source files
------------

// File: rtl/password_lock_ctrl.sv
// password_lock_ctrl: switch-edge 4-digit code lock with failed-attempt count.
// Timed lockout after MAX_TRIES failures only when PSWD_LOCKOUT_EN is defined.
module password_lock_ctrl #(
  parameter int unsigned CODE0       = 2,
  parameter int unsigned CODE1       = 0,
  parameter int unsigned CODE2       = 1,
  parameter int unsigned CODE3       = 6,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned OPEN_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  output logic [3:0] pswd_out_LED,
  output logic       unlocked,
  output logic       locked,
  output logic [2:0] fail_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENTRY  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_OPEN   = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  localparam logic [3:0]  C0       = 4'(CODE0);
  localparam logic [3:0]  C1       = 4'(CODE1);
  localparam logic [3:0]  C2       = 4'(CODE2);
  localparam logic [3:0]  C3       = 4'(CODE3);
  localparam logic [2:0]  MaxT     = 3'(MAX_TRIES);
  localparam logic [28:0] OpenLast = 29'(OPEN_CYCLES - 1);
  localparam logic [28:0] LockLast = 29'(LOCK_CYCLES - 1);

`ifdef PSWD_LOCKOUT_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic [9:0]  sw_q, edge_q, edge_d;
  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        mism_q, mism_d;
  logic [2:0]  fail_q, fail_d;
  logic [28:0] cnt_q, cnt_d;
  logic [3:0]  led_q, led_d;
  logic        unl_q, unl_d;
  logic        lck_q, lck_d;

  logic [3:0]  dig, exp_dig;
  logic        any_ev, bad;
  logic [2:0]  fail_inc;

  // Edge is registered, so the FSM consumes it one cycle after detection.
  assign edge_d = SW & ~sw_q;

  always_comb begin
    dig = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (edge_q[k]) dig = 4'(k);
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    exp_dig = C0;
      3'd1:    exp_dig = C1;
      3'd2:    exp_dig = C2;
      default: exp_dig = C3;
    endcase
  end

  assign any_ev   = |edge_q;
  assign bad      = !$onehot(edge_q) || (dig != exp_dig);
  assign fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mism_d  = mism_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q + 29'd1;
    case (state_q)
      S_IDLE: begin
        if (any_ev) begin
          idx_d   = 3'd1;
          mism_d  = bad;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (any_ev) begin
          idx_d  = idx_q + 3'd1;
          mism_d = mism_q | bad;
          if (idx_q == 3'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mism_q) begin
          state_d = S_FAIL;
          fail_d  = fail_inc;
        end else begin
          state_d = S_OPEN;
          fail_d  = 3'd0;
        end
      end
      S_OPEN: begin
        if (cnt_q == OpenLast) state_d = S_IDLE;
      end
      S_FAIL: begin
        if (LockEn && (fail_q >= MaxT)) state_d = S_LOCKED;
        else                            state_d = S_IDLE;
      end
      S_LOCKED: begin
        if (cnt_q == LockLast) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      idx_d  = 3'd0;
      mism_d = 1'b0;
    end
    if (state_d != state_q) cnt_d = 29'd0;
  end

  always_comb begin
    case (state_d)
      S_IDLE, S_ENTRY: begin
        case (idx_d)
          3'd1:    led_d = 4'b0001;
          3'd2:    led_d = 4'b0011;
          3'd3:    led_d = 4'b0111;
          default: led_d = 4'b0000;
        endcase
      end
      S_CHECK, S_OPEN: led_d = 4'b1111;
      S_LOCKED:        led_d = 4'b1010;
      default:         led_d = 4'b0000;
    endcase
    unl_d = (state_d == S_OPEN);
    lck_d = LockEn && (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    sw_q <= SW;
    if (!rst) begin
      edge_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      mism_q  <= 1'b0;
      fail_q  <= 3'd0;
      cnt_q   <= 29'd0;
      led_q   <= 4'b0000;
      unl_q   <= 1'b0;
      lck_q   <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      unl_q   <= unl_d;
      lck_q   <= lck_d;
    end
  end

  assign pswd_out_LED = led_q;
  assign unlocked     = unl_q;
  assign locked       = lck_q;
  assign fail_cnt     = fail_q;

endmodule
